apb_spi_master_param: RTL

//  Parametrised APB3 slave SPI master: next generation of the 16-bit single-SS APB-SPI block.

---
 rtl/apb_spi_pkg.sv | 7 +
 rtl/spi_fifo.sv | 37 +++
 rtl/apb_spi_master_param.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg: register indices, CTRL/STATUS bit positions and FSM state encoding shared by the APB SPI master
package apb_spi_pkg;
  localparam logic [2:0] REG_RX = 3'd0, REG_TX = 3'd1, REG_CTRL = 3'd2, REG_DIV = 3'd3, REG_STAT = 3'd4;
  localparam int C_EN = 0, C_CPOL = 1, C_CPHA = 2, C_IE_DONE = 3, C_IE_OVF = 4, C_SS = 8;
  localparam int S_RX_OVF = 5;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
endpackage

// File: rtl/spi_fifo.sv
// spi_fifo: sync show-ahead FIFO (clk, rst_n async low, push/din, pop/dout, full, empty); push while full is accepted only together with a pop
module spi_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/apb_spi_master_param.sv
// apb_spi_master_param: APB3 slave SPI master (APB: PCLK PRESETn PADDR PSEL0 PENABLE PWRITE PWDATA PRDATA PREADY PSLVERR; SPI: MISO MOSI SCLK SS_N; IRQ) with TX/RX FIFOs, CPOL/CPHA and SCLK divider
module apb_spi_master_param import apb_spi_pkg::*; #(
  parameter int APB_W   = 16,
  parameter int DATA_W  = 16,
  parameter int FIFO_D  = 4,
  parameter int NUM_SS  = 2,
  parameter int DIV_RST = 7
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [2:0]           PADDR,
  input  logic [2:0]           PPROT,
  input  logic                 PSEL0,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [APB_W-1:0]     PWDATA,
  input  logic [APB_W/8-1:0]   PSTRB,
  output logic                 PREADY,
  output logic [APB_W-1:0]     PRDATA,
  output logic                 PSLVERR,
  input  logic                 MISO,
  output logic                 MOSI,
  output logic                 SCLK,
  output logic [NUM_SS-1:0]    SS_N,
  output logic                 IRQ
);
  localparam int SSW = NUM_SS > 1 ? $clog2(NUM_SS) : 1;
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_H = HW'(2 * DATA_W - 1);
  localparam logic [APB_W-1:0] CTRL_MASK = APB_W'({{SSW{1'b1}}, 8'h1F});
  localparam logic [APB_W-1:0] OVF_BIT = APB_W'(1) << S_RX_OVF;
  localparam logic [NUM_SS-1:0] SS_ONE = NUM_SS'(1);
  logic access, wr, rd, err, wok, last, edge_go, lead, unused;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic [APB_W-1:0] ctrl, div, div_l, cnt, rdata;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_dout, rx_dout;
  logic [HW-1:0] h;
  logic rx_ovf, cpol, cpha;
  state_t st;
  assign unused = ^{PPROT, PSTRB};
  assign access = PSEL0 & PENABLE;
  assign wr = access & PWRITE;
  assign rd = access & !PWRITE;
  assign err = (PADDR > 3'd4)
             | (PWRITE & (PADDR == REG_RX))
             | (PWRITE & (PADDR == REG_TX) & tx_full)
             | (PWRITE & (PADDR == REG_STAT) & |(PWDATA & ~OVF_BIT))
             | (!PWRITE & (PADDR == REG_RX) & rx_empty);
  assign wok = wr & !err;
  assign PREADY = access;
  assign PSLVERR = access & err;
  assign PRDATA = (rd & !err) ? rdata : '0;
  assign IRQ = (ctrl[C_IE_DONE] & !rx_empty) | (ctrl[C_IE_OVF] & rx_ovf);
  always_comb
    case (PADDR)
      REG_RX:   rdata = APB_W'(rx_dout);
      REG_CTRL: rdata = ctrl;
      REG_DIV:  rdata = div;
      REG_STAT: rdata = APB_W'({rx_ovf, st != IDLE, rx_full, rx_empty, tx_full, tx_empty});
      default:  rdata = '0;
    endcase
  assign tx_push = wok & (PADDR == REG_TX);
  assign rx_pop = rd & !err & (PADDR == REG_RX);
  assign tx_pop = (st == IDLE) & ctrl[C_EN] & !tx_empty;
  assign last = cnt == div_l;
  assign edge_go = last & ((st == SETUP) | ((st == SHIFT) & (h != LAST_H)));
  assign lead = (st == SETUP) | h[0];
  assign rx_push = last & (st == SHIFT) & (h == LAST_H);
  spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_D)) u_tx (
    .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .din(PWDATA[DATA_W-1:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_D)) u_rx (
    .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      ctrl <= '0;
      div <= APB_W'(DIV_RST);
      rx_ovf <= 1'b0;
    end else begin
      if (wok & (PADDR == REG_CTRL)) ctrl <= PWDATA & CTRL_MASK;
      if (wok & (PADDR == REG_DIV)) div <= PWDATA;
      if (rx_push & rx_full & !rx_pop) rx_ovf <= 1'b1;
      else if (wok & (PADDR == REG_STAT) & PWDATA[S_RX_OVF]) rx_ovf <= 1'b0;
    end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      st <= IDLE;
      cnt <= '0;
      h <= '0;
      div_l <= '0;
      cpol <= 1'b0;
      cpha <= 1'b0;
      tx_sh <= '0;
      rx_sh <= '0;
      SS_N <= '1;
      SCLK <= 1'b0;
      MOSI <= 1'b0;
    end else begin
      cnt <= ((st == IDLE) || last) ? '0 : cnt + 1'b1;
      case (st)
        IDLE: begin
          SCLK <= ctrl[C_CPOL];
          if (tx_pop) begin
            st <= SETUP;
            cpol <= ctrl[C_CPOL];
            cpha <= ctrl[C_CPHA];
            div_l <= div;
            SS_N <= ~(SS_ONE << ctrl[C_SS +: SSW]);
            tx_sh <= ctrl[C_CPHA] ? tx_dout : tx_dout << 1;
            MOSI <= !ctrl[C_CPHA] & tx_dout[DATA_W-1];
          end
        end
        SETUP: if (last) begin
          st <= SHIFT;
          h <= '0;
        end
        SHIFT: if (last) begin
          if (h == LAST_H) st <= HOLD;
          else h <= h + 1'b1;
        end
        default: if (last) begin
          st <= IDLE;
          SS_N <= '1;
        end
      endcase
      if (edge_go) SCLK <= (st == SETUP) ? !cpol : !SCLK;
      if (edge_go & (lead ^ cpha)) rx_sh <= {rx_sh[DATA_W-2:0], MISO};
      if (edge_go & !(lead ^ cpha)) begin
        MOSI <= tx_sh[DATA_W-1];
        tx_sh <= tx_sh << 1;
      end
    end
endmodule
